aib_apb_initiator: RTL and testbench

APB-style bus initiator that drives the AIB control register bus: o_penable, o_pwrite, o_paddr and o_pwdata as master, with i_pready and i_prdata returned from the register target.
- Upstream, a command source (UART/JTAG bridge or test sequencer) issues single read/write requests over a valid/ready channel.
- Responses (read data plus error flag) return over a second valid/ready channel.
- One transaction is in flight at a time. A per-transaction timeout counter guards against a hung target.

---
 rtl/aib_apb_pkg.sv | 19 +
 rtl/aib_apb_initiator.sv | 141 ++++++++++++++
 tb/tb_aib_apb_initiator.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aib_apb_pkg.sv
// Shared types and constants for the AIB control-bus APB initiator.
//
// Contents:
//   apb_init_state_e  - initiator FSM states (IDLE, ACCESS, RESP)
//   DefaultTimeoutCyc - default access timeout in cycles
//   ErrRdata          - read data returned with an aborted transaction
package aib_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } apb_init_state_e;

    localparam int DefaultTimeoutCyc = 256;

    localparam logic [31:0] ErrRdata = '0;

endpackage

// File: rtl/aib_apb_initiator.sv
// APB-style initiator for the AIB control register bus.
//
// It accepts single read/write requests from a command source, runs one bus
// access at a time and returns read data and an error flag on a response
// channel. An access that sees no i_pready for TimeoutCyc cycles is aborted
// with an error, and a saturating counter tracks how many were aborted.
//
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_req_valid/o_req_ready   request handshake
//   i_req_write               1 = write, 0 = read
//   i_req_addr, i_req_wdata   byte address and write data
//   o_rsp_valid/i_rsp_ready   response handshake
//   o_rsp_rdata, o_rsp_err    read data (0 for writes/errors), timeout flag
//   o_penable, o_pwrite       bus strobe and direction
//   o_paddr, o_pwdata         word-aligned bus address and write data
//   i_pready, i_prdata        target completion and read data
//   o_busy                    a transaction is in progress
//   o_err_cnt                 saturating count of timed-out transactions
module aib_apb_initiator
    import aib_apb_pkg::*;
#(
    parameter int TimeoutCyc = DefaultTimeoutCyc,
    parameter int ErrCntW    = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_write,
    input  logic [31:0]        i_req_addr,
    input  logic [31:0]        i_req_wdata,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [31:0]        o_rsp_rdata,
    output logic               o_rsp_err,
    output logic               o_penable,
    output logic               o_pwrite,
    output logic [31:0]        o_paddr,
    output logic [31:0]        o_pwdata,
    input  logic               i_pready,
    input  logic [31:0]        i_prdata,
    output logic               o_busy,
    output logic [ErrCntW-1:0] o_err_cnt
);

    // Last count value before the access is abandoned; the counter is 16 bits
    // wide, which covers the full legal TimeoutCyc range.
    localparam logic [15:0] TmoLast = 16'(TimeoutCyc - 1);

    apb_init_state_e state;
    apb_init_state_e state_next;
    logic [15:0]     tmo_cnt;
    logic            tmo_hit;

    // The byte-lane bits of the request address never reach the bus.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^i_req_addr[1:0];

    assign o_req_ready = (state == IDLE);
    assign tmo_hit     = (tmo_cnt == TmoLast);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_req_valid) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // pready takes priority over an expiring timeout.
                if (i_pready || tmo_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            o_penable   <= 1'b0;
            o_pwrite    <= 1'b0;
            o_paddr     <= '0;
            o_pwdata    <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            o_busy      <= 1'b0;
            o_err_cnt   <= '0;
        end else begin
            state <= state_next;

            // Status outputs are registered from the next state so they line
            // up with the state they describe.
            o_penable   <= (state_next == ACCESS);
            o_rsp_valid <= (state_next == RESP);
            o_busy      <= (state_next != IDLE);

            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        o_pwrite <= i_req_write;
                        o_paddr  <= {i_req_addr[31:2], 2'b00};
                        o_pwdata <= i_req_wdata;
                    end
                end
                ACCESS: begin
                    if (i_pready) begin
                        // i_prdata is only looked at in the completing cycle.
                        o_rsp_rdata <= o_pwrite ? 32'h0 : i_prdata;
                        o_rsp_err   <= 1'b0;
                        tmo_cnt     <= '0;
                    end else if (tmo_hit) begin
                        o_rsp_rdata <= ErrRdata;
                        o_rsp_err   <= 1'b1;
                        tmo_cnt     <= '0;
                        if (o_err_cnt != {ErrCntW{1'b1}}) begin
                            o_err_cnt <= o_err_cnt + {{(ErrCntW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aib_apb_initiator.sv
module tb_aib_apb_initiator;

    localparam int TMO = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_write;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_penable;
    logic        o_pwrite;
    logic [31:0] o_paddr;
    logic [31:0] o_pwdata;
    logic        i_pready;
    logic [31:0] i_prdata;
    logic        o_busy;
    logic [15:0] o_err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t sb[$];
    int   acc_q[$];
    int   pen_start_q[$];
    int   pen_len_q[$];
    int   rsp_start_q[$];
    logic [31:0] pen_addr_q[$];
    logic [31:0] pen_data_q[$];
    int   pen_len  = 0;
    logic rsp_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aib_apb_initiator #(.TimeoutCyc(TMO), .ErrCntW(16)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_write (i_req_write),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .o_penable   (o_penable),
        .o_pwrite    (o_pwrite),
        .o_paddr     (o_paddr),
        .o_pwdata    (o_pwdata),
        .i_pready    (i_pready),
        .i_prdata    (i_prdata),
        .o_busy      (o_busy),
        .o_err_cnt   (o_err_cnt)
    );

    // Register target: mode 0 = pready in the first access cycle,
    // mode 1 = registered pready (second cycle), mode 2 = never ready.
    logic [31:0] regs [4096];
    int tgt_mode = 0;
    int tgt_cyc  = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) regs[i] <= 32'h0;
            regs[0] <= 32'h0000_0004;   // chn_mode resets to 3'b100
        end else if (o_penable && o_pwrite) begin
            regs[o_paddr[13:2]] <= o_pwdata;
        end
        tgt_cyc <= o_penable ? tgt_cyc + 1 : 0;
    end

    assign i_pready = o_penable && ((tgt_mode == 0) || (tgt_mode == 1 && tgt_cyc >= 1));
    assign i_prdata = i_pready ? regs[o_paddr[13:2]] : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: records bus activity and scores responses against the queue.
    always @(negedge clk) begin
        if (rst) begin
            pen_len  = 0;
            rsp_prev = 1'b0;
        end else begin
            if (i_req_valid && o_req_ready) acc_q.push_back(cyc);
            if (o_penable) begin
                if (pen_len == 0) begin
                    pen_start_q.push_back(cyc);
                    pen_addr_q.push_back(o_paddr);
                    pen_data_q.push_back(o_pwdata);
                end
                pen_len++;
            end else if (pen_len > 0) begin
                pen_len_q.push_back(pen_len);
                pen_len = 0;
            end
            if (o_rsp_valid && !rsp_prev) rsp_start_q.push_back(cyc);
            rsp_prev = o_rsp_valid;
            if (o_rsp_valid && i_rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_rdata", o_rsp_rdata, e.rdata);
                    chk("rsp_err", {31'h0, o_rsp_err}, {31'h0, e.err});
                end
            end
        end
    end

    task automatic clear_logs();
        acc_q.delete();
        pen_start_q.delete();
        pen_len_q.delete();
        rsp_start_q.delete();
        pen_addr_q.delete();
        pen_data_q.delete();
    endtask

    // Called and returns at posedge+1.
    task automatic send_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err);
        bit ok = 0;
        exp_t e;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb.push_back(e);
        i_req_valid = 1'b1;
        i_req_write = wr;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (o_req_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        if (!ok) begin
            chk("req_accept_timeout", 32'h0, 32'h1);
            void'(sb.pop_back());
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200; n++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            chk("rsp_drain_timeout", 32'(sb.size()), 32'h0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        i_req_valid = 1'b0;
        i_req_write = 1'b0;
        i_req_addr  = '0;
        i_req_wdata = '0;
        i_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'h0, o_req_ready}, 32'h1);
        chk("rst_penable", {31'h0, o_penable}, 32'h0);
        chk("rst_rsp_valid", {31'h0, o_rsp_valid}, 32'h0);
        chk("rst_busy", {31'h0, o_busy}, 32'h0);
        chk("rst_paddr", o_paddr, 32'h0);
        chk("rst_err_cnt", {16'h0, o_err_cnt}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Write with immediate pready.
        tgt_mode = 0;
        clear_logs();
        send_req(1'b1, 32'h0000_1000, 32'h0000_0ABC, 32'h0, 1'b0);
        wait_drain();
        chk("wr_pen_len", 32'(pen_len_q[0]), 32'd1);
        chk("wr_paddr", pen_addr_q[0], 32'h0000_1000);
        chk("wr_pwdata", pen_data_q[0], 32'h0000_0ABC);
        chk("wr_pen_at_T1", 32'(pen_start_q[0] - acc_q[0]), 32'd1);
        chk("wr_rsp_at_T2", 32'(rsp_start_q[0] - acc_q[0]), 32'd2);
        chk("wr_target_reg", regs[12'h400], 32'h0000_0ABC);

        // Read of chn_mode with registered pready, then read back the write.
        tgt_mode = 1;
        clear_logs();
        send_req(1'b0, 32'h0000_0000, 32'h0, 32'h0000_0004, 1'b0);
        wait_drain();
        chk("rd_pen_len", 32'(pen_len_q[0]), 32'd2);
        chk("rd_rsp_at_T3", 32'(rsp_start_q[0] - acc_q[0]), 32'd3);
        send_req(1'b0, 32'h0000_1000, 32'h0, 32'h0000_0ABC, 1'b0);
        wait_drain();

        // Timeouts.
        tgt_mode = 2;
        for (int k = 1; k <= 3; k++) begin
            clear_logs();
            send_req(k[0], 32'h0000_2000, 32'h55, 32'h0, 1'b1);
            wait_drain();
            chk("tmo_pen_len", 32'(pen_len_q[0]), 32'd4);
            chk("tmo_err_cnt", {16'h0, o_err_cnt}, 32'(k));
        end

        // Response backpressure.
        tgt_mode = 0;
        send_req(1'b1, 32'h0000_1010, 32'h1234_5678, 32'h0, 1'b0);
        wait_drain();
        tgt_mode = 1;
        i_rsp_ready = 1'b0;
        send_req(1'b0, 32'h0000_1010, 32'h0, 32'h1234_5678, 1'b0);
        for (int n = 0; n < 20; n++) begin
            if (o_rsp_valid) break;
            @(posedge clk);
            #1;
        end
        chk("bp_rsp_valid_seen", {31'h0, o_rsp_valid}, 32'h1);
        i_req_valid = 1'b1;
        i_req_write = 1'b1;
        i_req_addr  = 32'h0000_1000;
        i_req_wdata = 32'h0000_FFFF;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_rsp_valid", {31'h0, o_rsp_valid}, 32'h1);
            chk("bp_rdata", o_rsp_rdata, 32'h1234_5678);
            chk("bp_req_ready", {31'h0, o_req_ready}, 32'h0);
            chk("bp_penable", {31'h0, o_penable}, 32'h0);
        end
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        wait_drain();
        chk("bp_no_stray_write", regs[12'h400], 32'h0000_0ABC);

        // Reset in the middle of an access.
        tgt_mode = 2;
        send_req(1'b1, 32'h0000_1020, 32'h77, 32'h0, 1'b0);
        chk("mid_pen_before", {31'h0, o_penable}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_penable", {31'h0, o_penable}, 32'h0);
        chk("mid_busy", {31'h0, o_busy}, 32'h0);
        chk("mid_rsp_valid", {31'h0, o_rsp_valid}, 32'h0);
        chk("mid_req_ready", {31'h0, o_req_ready}, 32'h1);
        chk("mid_err_cnt", {16'h0, o_err_cnt}, 32'h0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tgt_mode = 0;
        clear_logs();
        send_req(1'b1, 32'h0000_1020, 32'h0000_0010, 32'h0, 1'b0);
        wait_drain();
        chk("mid_baud_reg", regs[12'h408], 32'h0000_0010);
        chk("mid_baud_pen_len", 32'(pen_len_q[0]), 32'd1);

        // Back-to-back alternating write/read on an unaligned address.
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            send_req(1'b1, 32'h0000_1003, 32'h100 + 32'(i), 32'h0, 1'b0);
            send_req(1'b0, 32'h0000_1003, 32'h0, 32'h100 + 32'(i), 1'b0);
        end
        wait_drain();
        chk("b2b_accepts", 32'(acc_q.size()), 32'd8);
        chk("b2b_pulses", 32'(pen_len_q.size()), 32'd8);
        if (acc_q.size() == 8 && pen_len_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("b2b_paddr", pen_addr_q[i], 32'h0000_1000);
                chk("b2b_pen_len", 32'(pen_len_q[i]), 32'd1);
            end
            // Spacing counted from one accept cycle up to and including the next.
            for (int i = 0; i < 4; i++) begin
                chk("b2b_wr_rd_spacing", 32'(acc_q[2*i+1] - acc_q[2*i] + 1), 32'd4);
            end
        end

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
